// File: rtl/uart_pkg.sv
// uart_pkg: shared receiver state encoding, default rates and bit-period helper (UART_RX_PARITY_EN adds PARITY)
package uart_pkg;
   localparam int DEF_CLK_HZ = 50_000_000;
   localparam int DEF_BAUD   = 115_200;
`ifdef UART_RX_PARITY_EN
   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_IDLE} state_t;
`else
   typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_IDLE} state_t;
`endif
   function automatic int clks_per_bit(input int clk_hz, input int baud);
      return clk_hz / baud;
   endfunction
endpackage

// File: rtl/uart_sync2.sv
// uart_sync2: two-flop synchronizer for an asynchronous input, reset value selectable
module uart_sync2 #(
   parameter logic RST_VAL = 1'b1
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);
   logic [1:0] ff;
   // shift the raw input through two stages
   always_ff @(posedge clk)
      if (rst) ff <= {2{RST_VAL}};
      else     ff <= {ff[0], d};
   assign q = ff[1];
endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver with valid/ready output and frame/overrun pulses (UART_RX_PARITY_EN selects 8E1)
module uart_rx
   import uart_pkg::*;
#(
   parameter int CLK_HZ = DEF_CLK_HZ,
   parameter int BAUD   = DEF_BAUD
) (
   input  logic       i_clk_50mhz,
   input  logic       i_reset,
   input  logic       i_rx,
   output logic [7:0] o_data,
   output logic       o_valid,
   input  logic       i_ready,
   output logic       o_frame_err,
   output logic       o_overrun,
   output logic       o_busy
);
   localparam int CPB = clks_per_bit(CLK_HZ, BAUD);
   localparam int CW  = $clog2(CPB + 1);
   localparam logic [CW-1:0] FULL = CW'(CPB);
   localparam logic [CW-1:0] HALF = CW'(CPB / 2);
   localparam logic [CW-1:0] ONE  = CW'(1);
   state_t state, state_n;
   logic [CW-1:0] cnt, cnt_n;
   logic [2:0] bit_idx, bit_idx_n;
   logic [7:0] shift, shift_n;
   logic rx_s, tick, deliver, ferr;
`ifdef UART_RX_PARITY_EN
   logic par_err, par_err_n;
`endif

   uart_sync2 #(.RST_VAL(1'b1)) u_sync (
      .clk (i_clk_50mhz),
      .rst (i_reset),
      .d   (i_rx),
      .q   (rx_s)
   );

   // cnt counts down to the next sample point; a sample is taken when it reaches one
   assign tick = (cnt == ONE);

   // state and datapath registers
   always_ff @(posedge i_clk_50mhz)
      if (i_reset) begin
         state   <= IDLE;
         cnt     <= '0;
         bit_idx <= '0;
         shift   <= '0;
`ifdef UART_RX_PARITY_EN
         par_err <= 1'b0;
`endif
      end else begin
         state   <= state_n;
         cnt     <= cnt_n;
         bit_idx <= bit_idx_n;
         shift   <= shift_n;
`ifdef UART_RX_PARITY_EN
         par_err <= par_err_n;
`endif
      end

   // frame sequencing: start-bit qualification, data shift, stop check
   always_comb begin
      state_n   = state;
      cnt_n     = (cnt != '0) ? cnt - ONE : cnt;
      bit_idx_n = bit_idx;
      shift_n   = shift;
      deliver   = 1'b0;
      ferr      = 1'b0;
`ifdef UART_RX_PARITY_EN
      par_err_n = par_err;
`endif
      case (state)
         IDLE:
            if (!rx_s) begin
               state_n = START;
               cnt_n   = HALF;
            end
         START:
            if (tick) begin
               state_n   = rx_s ? IDLE : DATA;
               cnt_n     = rx_s ? '0 : FULL;
               bit_idx_n = '0;
            end
         DATA:
            if (tick) begin
               shift_n   = {rx_s, shift[7:1]};
               cnt_n     = FULL;
               bit_idx_n = bit_idx + 3'd1;
`ifdef UART_RX_PARITY_EN
               state_n   = (bit_idx == 3'd7) ? PARITY : DATA;
`else
               state_n   = (bit_idx == 3'd7) ? STOP : DATA;
`endif
            end
`ifdef UART_RX_PARITY_EN
         PARITY:
            if (tick) begin
               par_err_n = rx_s ^ (^shift);
               cnt_n     = FULL;
               state_n   = STOP;
            end
`endif
         STOP:
            if (tick) begin
               cnt_n   = '0;
`ifdef UART_RX_PARITY_EN
               deliver = rx_s & ~par_err;
`else
               deliver = rx_s;
`endif
               ferr    = ~deliver;
               state_n = rx_s ? IDLE : WAIT_IDLE;
            end
         WAIT_IDLE:
            if (rx_s) state_n = IDLE;
         default:
            state_n = IDLE;
      endcase
   end

   // output holding register: a byte arriving while the old one is unconsumed is dropped
   always_ff @(posedge i_clk_50mhz)
      if (i_reset) begin
         o_data      <= 8'h00;
         o_valid     <= 1'b0;
         o_frame_err <= 1'b0;
         o_overrun   <= 1'b0;
      end else begin
         o_frame_err <= ferr;
         o_overrun   <= deliver & o_valid & ~i_ready;
         if (deliver && !(o_valid && !i_ready)) begin
            o_data  <= shift;
            o_valid <= 1'b1;
         end else if (o_valid && i_ready) begin
            o_valid <= 1'b0;
         end
      end

   assign o_busy = (state != IDLE);
endmodule
